// File: rtl/ddc_i2s_feeder_pkg.sv
// Shared constants for the DDC-to-I2S feeder: default sample width, FSM encoding
// and the saturating status-counter helper.
package ddc_i2s_feeder_pkg;

  localparam int WIDTH_DEFAULT = 24;

  localparam logic STATE_PRIME = 1'b0;
  localparam logic STATE_RUN   = 1'b1;

  localparam int                   CNT_WIDTH = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
    return (value == CNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/ddc_i2s_feeder_lrclk_tick.sv
// LRCLK synchroniser plus falling-edge detector; tick is a registered one-cycle
// pulse SYNC_STAGES+1 clocks after the LRCLK fall. SYNC_STAGES must be >= 2.
module feeder_lrclk_tick #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic lrclk_async,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced_prev;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync        <= '0;
      synced_prev <= 1'b0;
      tick        <= 1'b0;
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], lrclk_async};
      synced_prev <= sync[SYNC_STAGES-1];
      // Falling edge of the synchronised LRCLK marks the start of an I2S frame.
      tick        <= synced_prev & ~sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/ddc_i2s_feeder.sv
// Buffers DDC I/Q strobes and releases one pair per I2S frame, outputs held between.
// Build option FEEDER_RAMP_EN replaces popped data with a ramp / inverted ramp.
module ddc_i2s_feeder
  import ddc_i2s_feeder_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int DEPTH_LOG2  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_real,
  input  logic [WIDTH-1:0]     in_imag,
  input  logic                 lrclk_async,
  input  logic                 clear_status,
  output logic [WIDTH-1:0]     out_real,
  output logic [WIDTH-1:0]     out_imag,
  output logic [DEPTH_LOG2:0]  fifo_level,
  output logic                 running,
  output logic                 overrun,
  output logic                 underrun,
  output logic [CNT_WIDTH-1:0] overrun_cnt,
  output logic [CNT_WIDTH-1:0] underrun_cnt
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LEVEL_HALF = (DEPTH_LOG2+1)'(DEPTH / 2);

  logic [2*WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  state;
  logic                  tick;
  logic                  frame;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  over_ev;
  logic                  under_ev;
`ifdef FEEDER_RAMP_EN
  logic [WIDTH-1:0]      ramp;
`endif

  feeder_lrclk_tick #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tick (
    .clock       (clock),
    .reset       (reset),
    .lrclk_async (lrclk_async),
    .tick        (tick)
  );

  // All decisions use the pre-cycle level: no write-through, and a pop frees a
  // slot for a same-cycle push even when full.
  always_comb begin
    frame    = (state == STATE_RUN) && tick;
    full     = (fifo_level == LEVEL_FULL);
    pop      = frame && (fifo_level != '0);
    under_ev = frame && (fifo_level == '0);
    push     = in_valid && (!full || pop);
    over_ev  = in_valid && full && !pop;
  end

  assign running = (state == STATE_RUN);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {in_real, in_imag};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      state      <= STATE_PRIME;
      out_real   <= '0;
      out_imag   <= '0;
`ifdef FEEDER_RAMP_EN
      ramp       <= '0;
`endif
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
`ifdef FEEDER_RAMP_EN
        out_real <= ramp;
        out_imag <= ~ramp;
        ramp     <= ramp + 1'b1;
`else
        {out_real, out_imag} <= mem[rd_ptr];
`endif
      end

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      if (state == STATE_PRIME) begin
        if (fifo_level >= LEVEL_HALF) begin
          state <= STATE_RUN;
        end
      end else if (under_ev) begin
        state <= STATE_PRIME;
      end
    end
  end

  // A same-cycle event beats clear_status, leaving flag=1 and count=1.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overrun      <= 1'b0;
      overrun_cnt  <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (over_ev) begin
        overrun     <= 1'b1;
        overrun_cnt <= clear_status ? CNT_WIDTH'(1) : sat_inc(overrun_cnt);
      end else if (clear_status) begin
        overrun     <= 1'b0;
        overrun_cnt <= '0;
      end

      if (under_ev) begin
        underrun     <= 1'b1;
        underrun_cnt <= clear_status ? CNT_WIDTH'(1) : sat_inc(underrun_cnt);
      end else if (clear_status) begin
        underrun     <= 1'b0;
        underrun_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ddc_i2s_feeder.sv
// Directed bench for ddc_i2s_feeder (DEPTH=8, SYNC_STAGES=2); expected pops come
// from a queue of accepted pairs, or from a ramp when FEEDER_RAMP_EN is defined.
module tb_ddc_i2s_feeder;

  localparam int W     = 24;
  localparam int DL2   = 3;
  localparam int SS    = 2;
  localparam int DEPTH = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_real = '0;
  logic [W-1:0] in_imag = '0;
  logic         lrclk_async = 1'b0;
  logic         clear_status = 1'b0;
  logic [W-1:0] out_real;
  logic [W-1:0] out_imag;
  logic [DL2:0] fifo_level;
  logic         running;
  logic         overrun;
  logic         underrun;
  logic [7:0]   overrun_cnt;
  logic [7:0]   underrun_cnt;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   last_real = '0;
  logic [W-1:0]   last_imag = '0;
  logic [W-1:0]   ramp_n = '0;
  int             n_checks = 0;
  int             n_fail = 0;

  ddc_i2s_feeder #(
    .WIDTH       (W),
    .DEPTH_LOG2  (DL2),
    .SYNC_STAGES (SS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_real      (in_real),
    .in_imag      (in_imag),
    .lrclk_async  (lrclk_async),
    .clear_status (clear_status),
    .out_real     (out_real),
    .out_imag     (out_imag),
    .fifo_level   (fifo_level),
    .running      (running),
    .overrun      (overrun),
    .underrun     (underrun),
    .overrun_cnt  (overrun_cnt),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_real"}, 48'(out_real), 48'(last_real));
    check({tag, "_imag"}, 48'(out_imag), 48'(last_imag));
  endtask

  // Pushes I=v, Q=-v; the model keeps it only if there is room.
  task automatic push(input logic [W-1:0] v);
    in_valid = 1'b1;
    in_real  = v;
    in_imag  = -v;
    step();
    in_valid = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back({v, -v});
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
  endtask

  // One LRCLK period ending in a fall; returns #1 after the pop edge
  // (SYNC_STAGES+2 clocks after the fall). Optional push lands on the tick cycle.
  task automatic frame(input bit with_push, input logic [W-1:0] v, input bit pop_expected);
    logic [2*W-1:0] e;
    lrclk_async = 1'b1;
    repeat (4) step();
    lrclk_async = 1'b0;
    repeat (SS + 1) step();
    if (with_push) begin
      in_valid = 1'b1;
      in_real  = v;
      in_imag  = -v;
    end
    step();
    in_valid = 1'b0;
    if (pop_expected && exp_q.size() > 0) begin
      e = exp_q.pop_front();
`ifdef FEEDER_RAMP_EN
      last_real = ramp_n;
      last_imag = ~ramp_n;
      ramp_n    = ramp_n + 1'b1;
`else
      last_real = e[2*W-1:W];
      last_imag = e[W-1:0];
`endif
    end
    if (with_push && exp_q.size() < DEPTH) exp_q.push_back({v, -v});
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b1;
    step();
    check("rst_out_real", 48'(out_real), 48'h0);
    check("rst_out_imag", 48'(out_imag), 48'h0);
    check("rst_level", 48'(fifo_level), 48'd0);
    check("rst_running", 48'(running), 48'd0);
    check("rst_flags", 48'({overrun, underrun}), 48'd0);
    check("rst_cnts", 48'({overrun_cnt, underrun_cnt}), 48'd0);

    // Prime with four pairs, then the first frame pops pair 1.
    for (int k = 1; k <= 4; k++) push(W'(k));
    check("prime_level", 48'(fifo_level), 48'd4);
    check("prime_not_yet_running", 48'(running), 48'd0);
    step();
    check("prime_running", 48'(running), 48'd1);
    frame(1'b0, '0, 1'b1);
`ifdef FEEDER_RAMP_EN
    check("first_pop_real", 48'(out_real), 48'h000000);
`else
    check("first_pop_real", 48'(out_real), 48'h000001);
`endif
    check("first_pop_imag", 48'(out_imag), 48'hFFFFFF);
    check("first_pop_level", 48'(fifo_level), 48'd3);
    for (int k = 0; k < 3; k++) begin
      frame(1'b0, '0, 1'b1);
      check_out("drain_a");
    end
    check("drain_a_level", 48'(fifo_level), 48'd0);

    // Ten pushes into an empty FIFO: eight kept, two dropped.
    for (int k = 1; k <= 10; k++) push(W'(24'h100 + k));
    check("ovr_level", 48'(fifo_level), 48'd8);
    check("ovr_flag", 48'(overrun), 48'd1);
    check("ovr_cnt", 48'(overrun_cnt), 48'd2);
    for (int k = 0; k < 8; k++) begin
      frame(1'b0, '0, 1'b1);
      check_out("ovr_pop");
    end
    check("ovr_drained", 48'(fifo_level), 48'd0);
    check("ovr_still_run", 48'(running), 48'd1);

    // One entry, two frames: a pop then an underrun back to PRIME.
    push(24'h200);
    frame(1'b0, '0, 1'b1);
    check_out("one_entry_pop");
    frame(1'b0, '0, 1'b0);
    check("udr_flag", 48'(underrun), 48'd1);
    check("udr_cnt", 48'(underrun_cnt), 48'd1);
    check("udr_running", 48'(running), 48'd0);
    check_out("udr_hold");

    pulse_clear();
    check("clr_flags", 48'({overrun, underrun}), 48'd0);
    check("clr_cnts", 48'({overrun_cnt, underrun_cnt}), 48'd0);

    // Full FIFO plus push on the tick cycle: accepted, no overrun.
    for (int k = 1; k <= 8; k++) push(W'(24'h300 + k));
    check("full_level", 48'(fifo_level), 48'd8);
    check("full_running", 48'(running), 48'd1);
    frame(1'b1, 24'h3FF, 1'b1);
    check_out("full_push_pop");
    check("full_push_level", 48'(fifo_level), 48'd8);
    check("full_push_no_ovr", 48'(overrun), 48'd0);
    for (int k = 0; k < 8; k++) begin
      frame(1'b0, '0, 1'b1);
      check_out("full_drain");
    end
    check("full_drained", 48'(fifo_level), 48'd0);

    // Empty FIFO plus push on the tick cycle: underrun, sample kept.
    frame(1'b1, 24'h400, 1'b0);
    check("empty_push_udr", 48'(underrun), 48'd1);
    check("empty_push_udr_cnt", 48'(underrun_cnt), 48'd1);
    check("empty_push_level", 48'(fifo_level), 48'd1);
    check("empty_push_prime", 48'(running), 48'd0);
    check_out("empty_push_hold");

    // Saturate the overrun counter, clear, then event-beats-clear.
    for (int k = 1; k <= 7; k++) push(W'(24'h400 + k));
    check("sat_fill_level", 48'(fifo_level), 48'd8);
    for (int k = 0; k < 300; k++) push(24'h500);
    check("sat_cnt", 48'(overrun_cnt), 48'd255);
    check("sat_flag", 48'(overrun), 48'd1);
    pulse_clear();
    check("sat_clr_cnt", 48'(overrun_cnt), 48'd0);
    check("sat_clr_flag", 48'(overrun), 48'd0);
    check("sat_clr_udr", 48'({underrun, underrun_cnt}), 48'd0);
    check("sat_clr_level", 48'(fifo_level), 48'd8);
    clear_status = 1'b1;
    push(24'h501);
    clear_status = 1'b0;
    check("evt_wins_flag", 48'(overrun), 48'd1);
    check("evt_wins_cnt", 48'(overrun_cnt), 48'd1);
    for (int k = 0; k < 8; k++) begin
      frame(1'b0, '0, 1'b1);
      check_out("intact_pop");
    end
    check("intact_level", 48'(fifo_level), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddc_i2s_feeder.md
Name: ddc_i2s_feeder

Overview:
Sits between the DDC decimator output and the I2S slave transmitter. It buffers the 24-bit I/Q samples that the DDC emits as strobes on the system clock. It releases exactly one I/Q pair per I2S frame, paced by a locally synchronised LRCLK. Between frames its outputs hold steady, so the I2S block can resample them safely.

Parameters:
WIDTH, 24, sample width of each of I and Q
DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 I/Q pairs
SYNC_STAGES, 2, flip-flop stages on LRCLK synchroniser (min 2)

Ports:
clock  in  1  DDC system clock
reset  in  1  synchronous, active-low
in_valid  in  1  one-cycle strobe: in_real/in_imag valid
in_real  in  WIDTH  DDC I sample, two's complement
in_imag  in  WIDTH  DDC Q sample, two's complement
lrclk_async  in  1  raw I2S LRCLK, asynchronous to clock
clear_status  in  1  one-cycle pulse: clear sticky flags and counters
out_real  out  WIDTH  held I sample to I2S transmitter
out_imag  out  WIDTH  held Q sample to I2S transmitter
fifo_level  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH
running  out  1  1 in RUN state
overrun  out  1  sticky: sample dropped on full FIFO
underrun  out  1  sticky: frame tick with empty FIFO in RUN
overrun_cnt  out  8  saturating count of dropped samples
underrun_cnt  out  8  saturating count of underruns

Behaviour:
- Reset (reset==0 at clock edge): all outputs 0; FIFO pointers 0; synchroniser and edge register 0; state PRIME.
- Frame tick:
  - LRCLK passes through SYNC_STAGES flip-flops, then an edge register.
  - tick = previous synced value 1 AND current synced value 0 (falling edge = frame start).
  - tick is a single-cycle pulse, registered SYNC_STAGES+1 clocks after the LRCLK fall.
- Push: in_valid and level<DEPTH writes {in_real,in_imag} at the write pointer.
- Overrun: in_valid with level==DEPTH drops the sample, sets overrun, and increments overrun_cnt (saturates at 255).
- Pointers are DEPTH_LOG2 bits and wrap naturally. fifo_level is tracked separately.
- FSM:
  - PRIME: tick is ignored and outputs hold. When level >= DEPTH/2 at a clock edge, go to RUN on the next cycle.
  - RUN, tick with level>0: pop head into out_real/out_imag on the following edge (one-cycle pop latency), level decrements.
  - RUN, tick with level==0: outputs hold last value; set underrun; underrun_cnt increments (saturating); go to PRIME.
- Simultaneous push and pop in the same cycle:
  - level unchanged; both happen.
  - Pop evaluation uses the pre-cycle level; there is no write-through bypass. Empty FIFO plus push plus tick in RUN counts as underrun, and the pushed sample is kept.
  - Full FIFO plus push plus tick is not an overrun: the pop frees a slot and the push is accepted.
- clear_status:
  - Zeroes overrun, underrun and both counters; does not touch FIFO or state.
  - If an overrun or underrun event occurs in the same cycle, the event wins (flag=1, count=1).
- Outputs change only on a pop edge (or reset), and at most once per LRCLK period.

Optional Feature:
- Macro: FEEDER_RAMP_EN.
- Defined: each pop presents out_real = ramp and out_imag = ~ramp instead of FIFO data, where ramp is a WIDTH-bit counter that resets to 0 and increments per successful pop. FIFO, FSM and status behave identically. Used for bit-exact I2S link checks.
- Undefined: the ramp logic is absent and outputs carry FIFO data.

Decomposition:
- Shared package: WIDTH default, the FSM state encoding (PRIME=1'b0, RUN=1'b1), and the 8-bit counter width/saturation constant.
- One natural sub-module: feeder_lrclk_tick (synchroniser plus falling-edge detector, parameter SYNC_STAGES). FIFO storage stays inline.

Test Plan:
- Reset, then push 4 pairs (I=0x000001..0x000004, Q=negated). PRIME→RUN after 4th push (DEPTH=8). Next LRCLK fall → out_real=0x000001, out_imag=0xFFFFFF after SYNC_STAGES+2 clocks; level 3.
- Push 10 pairs with no LRCLK → level 8, overrun=1, overrun_cnt=2; pops return pairs 1..8 in order.
- RUN with 1 entry, 2 LRCLK falls → first pops entry; second gives underrun=1, underrun_cnt=1, running=0, outputs unchanged.
- Level 8, in_valid on the tick cycle → no overrun, level stays 8; same with level 0 in RUN → underrun, level becomes 1.
- 300 overruns then clear_status on a non-event cycle → count saturates at 255, then reads 0, flag 0; FIFO contents intact.
- FEEDER_RAMP_EN defined, 3 pops → out_real 0,1,2; out_imag 0xFFFFFF,0xFFFFFE,0xFFFFFD.
